fact_engine: RTL and testbench
==============================

# fact_engine

Sequential factorial engine for the UART factorial calculator. Downstream of the UART receiver: takes an 8-bit operand n, computes n! with an iterative 8-cycle shift-add multiplier, and flags overflow past RES_W bits. Presents the result to the transmit-side formatter over a valid/ready handshake.

## Interface
- RES_W, 64: result width in bits; must be ≥ 16. With 64, 20! is the largest representable result.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle operand strobe, driven by the receiver's done strobe delayed one clk so that operand is valid in the same cycle.
- operand  input  8  n, unsigned, sampled when start=1 in IDLE.
- res_ready  input  1  consumer accepts result when high with res_valid.
- busy  output  1  high whenever state ≠ IDLE.
- res_valid  output  1  result/ovf valid, held until accepted.
- result  output  RES_W  n! (unsigned); 0 when ovf=1.
- ovf  output  1  n! does not fit in RES_W bits.

## Operation
- Registers: n_reg[7:0], i_reg[8:0] (multiplier counter, 9 bits so n+1=256 cannot wrap), acc[RES_W-1:0], prod[RES_W+7:0], k[2:0] (bit index).
- States: IDLE, CHECK, MUL, DONE.
- IDLE: start=1 → n_reg=operand, acc=1, i_reg=2, result=0, ovf=0 → CHECK. start=0 → stay.
- CHECK: if i_reg > {1'b0,n_reg} → result=acc, ovf=0 → DONE. Else prod=0, k=0 → MUL.
- MUL (8 cycles, k=0..7): if i_reg[k] then prod += {8'b0,acc} << k (width RES_W+8, no truncation). k increments each cycle.
- End of MUL (k=7, using prod including that cycle's addend): if prod[RES_W+7:RES_W] ≠ 0 → result=0, ovf=1 → DONE (remaining iterations abandoned). Else acc=prod[RES_W-1:0], i_reg=i_reg+1 → CHECK.
- DONE: res_valid=1; result and ovf held stable. res_valid&res_ready → IDLE next cycle.
- n=0 and n=1 both yield result=1, ovf=0 (no multiply executed).
- start while state ≠ IDLE (including DONE): ignored, no effect on operand or computation.
- result/ovf retain their last values after handshake until the next accepted start clears them.
- Reset (any cycle, including mid-MUL or DONE): state=IDLE, busy=0, res_valid=0, result=0, ovf=0, all internal registers 0.

## Timing
- Cycle 0 = cycle in which start=1 is sampled in IDLE; busy high from cycle 1.
- CHECK at cycle 1; multiply j (j=1,2,…) occupies MUL cycles 9j-7 .. 9j; CHECK follows at 9j+1.
- Latency to res_valid=1: n≤1 → cycle 2; 2≤n≤20 (RES_W=64) → cycle 9(n-1)+2; overflow detected at multiply j → DONE at cycle 9j+1 (RES_W=64: n≥21 → cycle 181).
- res_valid registered, asserted the cycle DONE is entered; with res_ready already high, handshake completes that cycle, IDLE next cycle, busy low then.
- New start accepted earliest the cycle after return to IDLE; start coincident with handshake cycle is ignored.
- No combinational path from any input to any output.

## Test plan
- Reset then operand=5, start pulse, res_ready=1 → res_valid high at cycle 38, result=120, ovf=0; busy low at cycle 39.
- operand=0, then separately operand=1 → each res_valid at cycle 2, result=1, ovf=0.
- operand=20 → cycle 173, result=2432902008176640000, ovf=0; operand=21 and operand=255 → cycle 181, result=0, ovf=1.
- operand=3, res_ready held low 10 cycles after res_valid (cycle 20) → result=6 and res_valid stable throughout; extra start pulses (operand=9) during busy and DONE ignored; IDLE one cycle after res_ready rises.
- operand=10, reset asserted at cycle 40 for one cycle → all outputs 0 next cycle; then operand=4 → result=24 at cycle 29 after its start.
- Back-to-back: operand=2 accepted, handshake, start on cycle after IDLE return with operand=6 → result=720 at cycle 47 of second request.

Source files
------------

// File: rtl/fact_engine.sv
// Sequential factorial engine: n! built up by repeated 8-cycle shift-add
// multiplies, with overflow detection past RES_W bits and a valid/ready result port.
module fact_engine #(
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       operand,
  input  logic             res_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [RES_W-1:0] result,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [7:0]         n_reg;
  logic [8:0]         i_reg;
  logic [RES_W-1:0]   acc;
  logic [RES_W+7:0]   prod;
  logic [2:0]         k;

  logic [RES_W+7:0]   addend;
  logic [RES_W+7:0]   prod_sum;

  // One multiplier bit per MUL cycle; prod_sum already includes this cycle's addend.
  always_comb begin
    addend   = '0;
    prod_sum = '0;
    if (i_reg[k]) begin
      addend = {8'b0, acc} << k;
    end
    prod_sum = prod + addend;
  end

  // Result port: res_valid stays high with result/ovf frozen until a cycle
  // with res_valid && res_ready; the engine returns to IDLE on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      n_reg     <= '0;
      i_reg     <= '0;
      acc       <= '0;
      prod      <= '0;
      k         <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg  <= operand;
            acc    <= {{(RES_W-1){1'b0}}, 1'b1};
            i_reg  <= 9'd2;
            result <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (i_reg > {1'b0, n_reg}) begin
            result    <= acc;
            ovf       <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            prod  <= '0;
            k     <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          prod <= prod_sum;
          k    <= k + 3'd1;
          if (k == 3'd7) begin
            // Any bit above RES_W means n! cannot be represented; stop early.
            if (|prod_sum[RES_W+7:RES_W]) begin
              result    <= '0;
              ovf       <= 1'b1;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc   <= prod_sum[RES_W-1:0];
              i_reg <= i_reg + 9'd1;
              state <= CHECK;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_fact_engine.sv
// Directed bench for fact_engine: latency, values, overflow, backpressure,
// mid-run reset and back-to-back requests, each checked against hand-computed values.
module tb_fact_engine;

  localparam int RES_W = 64;

  logic             clk;
  logic             reset;
  logic             start;
  logic [7:0]       operand;
  logic             res_ready;
  logic             busy;
  logic             res_valid;
  logic [RES_W-1:0] result;
  logic             ovf;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  fact_engine #(.RES_W(RES_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand   (operand),
    .res_ready (res_ready),
    .busy      (busy),
    .res_valid (res_valid),
    .result    (result),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge of cycle 1 with start low.
  task automatic do_start(input logic [7:0] op);
    start   = 1'b1;
    operand = op;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of cycle 1; returns at the negedge where res_valid
  // is first seen high (cyc = that cycle) or when the limit is reached.
  task automatic wait_valid(input int limit, input int pulse_at, output int cyc);
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == pulse_at) begin
        start   = 1'b1;
        operand = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string name, input logic [RES_W-1:0] exp_res, input logic exp_ovf);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL %s idle: busy=%b valid=%b state=%0d required 0 0 0", name, busy, res_valid, state_dbg);
    end
    checks++;
    if (result !== exp_res || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s held: result=%0d ovf=%b required %0d %b", name, result, ovf, exp_res, exp_ovf);
    end
  endtask

  task automatic run_one(input string name, input logic [7:0] op, input int exp_cyc,
                         input logic [RES_W-1:0] exp_res, input logic exp_ovf);
    int cyc;
    res_ready = 1'b1;
    do_start(op);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_c1: busy=%b required 1", name, busy);
    end
    wait_valid(400, 0, cyc);
    checks++;
    if (cyc !== exp_cyc || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: cycle=%0d valid=%b required %0d 1", name, cyc, res_valid, exp_cyc);
    end
    checks++;
    if (result !== exp_res || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s value: result=%0d ovf=%b required %0d %b", name, result, ovf, exp_res, exp_ovf);
    end
    @(negedge clk);
    check_idle(name, exp_res, exp_ovf);
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b0;
    operand   = 8'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset", '0, 1'b0);
  endtask

  task automatic test_basic;
    run_one("fact5", 8'd5, 38, 64'd120, 1'b0);
    run_one("fact0", 8'd0, 2, 64'd1, 1'b0);
    run_one("fact1", 8'd1, 2, 64'd1, 1'b0);
    run_one("fact2", 8'd2, 11, 64'd2, 1'b0);
  endtask

  task automatic test_boundary;
    run_one("fact20", 8'd20, 173, 64'd2432902008176640000, 1'b0);
    run_one("fact21", 8'd21, 181, 64'd0, 1'b1);
    run_one("fact255", 8'd255, 181, 64'd0, 1'b1);
  endtask

  task automatic test_backpressure;
    int cyc;
    res_ready = 1'b0;
    do_start(8'd3);
    wait_valid(400, 5, cyc);
    checks++;
    if (cyc !== 20 || result !== 64'd6 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL hold latency: cycle=%0d result=%0d ovf=%b required 20 6 0", cyc, result, ovf);
    end
    for (int i = 0; i < 10; i++) begin
      start   = (i % 3 == 0);
      operand = 8'd9;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || result !== 64'd6 || ovf !== 1'b0 || state_dbg !== 2'd3) begin
        errors++;
        $display("FAIL hold stable[%0d]: valid=%b result=%0d ovf=%b state=%0d required 1 6 0 3",
                 i, res_valid, result, ovf, state_dbg);
      end
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check_idle("hold_release", 64'd6, 1'b0);
  endtask

  task automatic test_mid_reset;
    int cyc;
    res_ready = 1'b1;
    do_start(8'd10);
    wait_valid(40, 0, cyc);
    checks++;
    if (cyc !== 40 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst pre: cycle=%0d busy=%b valid=%b required 40 1 0", cyc, busy, res_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midrst", '0, 1'b0);
    run_one("fact4", 8'd4, 29, 64'd24, 1'b0);
  endtask

  task automatic test_back_to_back;
    int cyc;
    res_ready = 1'b1;
    do_start(8'd2);
    wait_valid(400, 0, cyc);
    checks++;
    if (cyc !== 11 || result !== 64'd2) begin
      errors++;
      $display("FAIL b2b first: cycle=%0d result=%0d required 11 2", cyc, result);
    end
    // start during the handshake cycle must be dropped
    start   = 1'b1;
    operand = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check_idle("b2b_hs", 64'd2, 1'b0);
    run_one("b2b_fact6", 8'd6, 47, 64'd720, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
